// File: rtl/speaker_drive.sv
// speaker_drive: four square-wave tone generators, saturating BGM+SFX mixer and 16-bit I2S serialiser.
// Build option SPEAKER_DUCK_EN halves the BGM sample on any channel whose SFX divisor is > 1.
module speaker_drive #(
   parameter int DIV_W = 22,
   parameter int AMP_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] bgm_note_div_left,
   input  logic [DIV_W-1:0] bgm_note_div_right,
   input  logic [AMP_W-1:0] bgm_amplitude,
   input  logic [DIV_W-1:0] sfx_note_div_left,
   input  logic [DIV_W-1:0] sfx_note_div_right,
   input  logic [AMP_W-1:0] sfx_amplitude,
   output logic             audio_mclk,
   output logic             audio_lrck,
   output logic             audio_sck,
   output logic             audio_sdin
);
   localparam logic [AMP_W-1:0] MAG_MAX = {1'b0, {(AMP_W-1){1'b1}}};
   localparam logic [AMP_W-1:0] MAG_MIN = {1'b1, {(AMP_W-1){1'b0}}};

   // Source order: 0 BGM-L, 1 BGM-R, 2 SFX-L, 3 SFX-R
   logic [DIV_W-1:0]        div    [4];
   logic [AMP_W-1:0]        amp    [4];
   logic signed [AMP_W-1:0] sample [4];
   logic [AMP_W-1:0]        mix    [2];

   assign div[0] = bgm_note_div_left;
   assign div[1] = bgm_note_div_right;
   assign div[2] = sfx_note_div_left;
   assign div[3] = sfx_note_div_right;
   assign amp[0] = bgm_amplitude;
   assign amp[1] = bgm_amplitude;
   assign amp[2] = sfx_amplitude;
   assign amp[3] = sfx_amplitude;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : gen_tone
         logic [DIV_W-1:0] tc_reg;
         logic             sq_reg;
         logic             silent;
         logic [AMP_W-1:0] mag;

         assign silent = (div[gi] <= DIV_W'(1));
         assign mag    = (amp[gi] > MAG_MAX) ? MAG_MAX : amp[gi];

         // The >= compare lets a divisor that shrinks below tc wrap at once
         always_ff @(posedge clk) begin
            if (rst || silent) begin
               tc_reg <= '0;
               sq_reg <= 1'b0;
            end else if (tc_reg >= div[gi] - DIV_W'(1)) begin
               tc_reg <= '0;
               sq_reg <= ~sq_reg;
            end else begin
               tc_reg <= tc_reg + DIV_W'(1);
            end
         end

         assign sample[gi] = silent ? '0 : (sq_reg ? mag : AMP_W'(0) - mag);
      end

      for (genvar gi = 0; gi < 2; gi++) begin : gen_mix
         logic signed [AMP_W-1:0] bgm;
         logic signed [AMP_W-1:0] sfx;
         logic [AMP_W:0]          sum;
`ifdef SPEAKER_DUCK_EN
         assign bgm = (div[gi+2] > DIV_W'(1)) ? (sample[gi] >>> 1) : sample[gi];
`else
         assign bgm = sample[gi];
`endif
         assign sfx = sample[gi+2];
         assign sum = {bgm[AMP_W-1], bgm} + {sfx[AMP_W-1], sfx};
         assign mix[gi] = (sum[AMP_W] == sum[AMP_W-1]) ? sum[AMP_W-1:0]
                        : (sum[AMP_W] ? MAG_MIN : MAG_MAX);
      end
   endgenerate

   logic [8:0]       cnt_reg;
   logic [8:0]       cnt_next;
   logic [AMP_W-1:0] word_l_reg;
   logic [AMP_W-1:0] word_r_reg;
   logic [AMP_W-1:0] prev_r_reg;
   logic [AMP_W-1:0] prev_r_next;
   logic             sdin_reg;
   logic             sdin_next;
   logic             capture;
   logic [3:0]       slot;
   logic [3:0]       bit_idx;

   assign cnt_next    = cnt_reg + 9'd1;
   assign capture     = (cnt_reg == 9'd511);
   assign prev_r_next = capture ? word_r_reg : prev_r_reg;
   assign slot        = cnt_next[7:4];
   // Slot s carries bit 16-s; modulo 16 this makes slot 0 select bit 0
   assign bit_idx     = 4'd0 - slot;

   always_comb begin
      sdin_next = sdin_reg;
      if (cnt_next[3:0] == 4'd0) begin
         if (!cnt_next[8])
            sdin_next = (slot == 4'd0) ? prev_r_next[0] : word_l_reg[bit_idx];
         else
            sdin_next = (slot == 4'd0) ? word_l_reg[0] : word_r_reg[bit_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg    <= '0;
         word_l_reg <= '0;
         word_r_reg <= '0;
         prev_r_reg <= '0;
         sdin_reg   <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         prev_r_reg <= prev_r_next;
         sdin_reg   <= sdin_next;
         if (capture) begin
            word_l_reg <= mix[0];
            word_r_reg <= mix[1];
         end
      end
   end

   assign audio_mclk = cnt_reg[1];
   assign audio_sck  = cnt_reg[3];
   assign audio_lrck = cnt_reg[8];
   assign audio_sdin = sdin_reg;
endmodule

// File: tb/tb_speaker_drive.sv
// Bench for speaker_drive: closed-form tone model feeds a scoreboard of expected frame words,
// which are compared against words decoded from the I2S stream.
module tb_speaker_drive;
   logic        clk;
   logic        rst;
   logic [21:0] bgm_note_div_left;
   logic [21:0] bgm_note_div_right;
   logic [15:0] bgm_amplitude;
   logic [21:0] sfx_note_div_left;
   logic [21:0] sfx_note_div_right;
   logic [15:0] sfx_amplitude;
   logic        audio_mclk;
   logic        audio_lrck;
   logic        audio_sck;
   logic        audio_sdin;

   int          vectors = 0;
   int          miscompares = 0;
   int          step = 0;
   bit          fresh = 0;
   int          base_n [4];
   bit          base_sq [4];
   logic [31:0] exp_q [$];
   logic [15:0] got_l, got_r;

   speaker_drive dut (
      .clk(clk),
      .rst(rst),
      .bgm_note_div_left(bgm_note_div_left),
      .bgm_note_div_right(bgm_note_div_right),
      .bgm_amplitude(bgm_amplitude),
      .sfx_note_div_left(sfx_note_div_left),
      .sfx_note_div_right(sfx_note_div_right),
      .sfx_amplitude(sfx_amplitude),
      .audio_mclk(audio_mclk),
      .audio_lrck(audio_lrck),
      .audio_sck(audio_sck),
      .audio_sdin(audio_sdin)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Clock edges since the last reset edge
   always @(posedge clk) begin
      if (rst) begin
         step  <= 0;
         fresh <= 1'b1;
      end else begin
         step  <= step + 1;
         fresh <= 1'b0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at step %0d", tag, got, want, step);
      end
   endtask

   function automatic int div_of(input int i);
      case (i)
         0: return int'(bgm_note_div_left);
         1: return int'(bgm_note_div_right);
         2: return int'(sfx_note_div_left);
         default: return int'(sfx_note_div_right);
      endcase
   endfunction

   task automatic set_div(input int i, input logic [21:0] v);
      case (i)
         0: bgm_note_div_left = v;
         1: bgm_note_div_right = v;
         2: sfx_note_div_left = v;
         default: sfx_note_div_right = v;
      endcase
   endtask

   // Square bit after n edges: toggles every div edges from the recorded base point
   function automatic bit sq_of(input int i, input int n);
      int d;
      d = div_of(i);
      if (d <= 1) return 1'b0;
      return base_sq[i] ^ ((((n - base_n[i]) / d) % 2) == 1);
   endfunction

   function automatic int src_val(input int i, input int n);
      int m;
      m = (i < 2) ? int'(bgm_amplitude) : int'(sfx_amplitude);
      if (m > 32767) m = 32767;
      if (div_of(i) <= 1) return 0;
      return sq_of(i, n) ? m : -m;
   endfunction

   function automatic logic [15:0] mix_exp(input int ch, input int n);
      int b, s, t;
      b = src_val(ch, n);
      s = src_val(ch + 2, n);
`ifdef SPEAKER_DUCK_EN
      if (div_of(ch + 2) > 1) b = b >>> 1;
`endif
      t = b + s;
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      return 16'(t);
   endfunction

   // Divisor change applied after edge n, taking effect on edge n+1
   task automatic retune(input int i, input int n, input logic [21:0] nd);
      int d, tc;
      bit s;
      d  = div_of(i);
      tc = (n - base_n[i]) % d;
      s  = sq_of(i, n);
      set_div(i, nd);
      if (tc >= int'(nd) - 1) begin
         base_n[i]  = n + 1;
         base_sq[i] = !s;
      end else begin
         base_n[i]  = n - tc;
         base_sq[i] = s;
      end
   endtask

   task automatic wait_step(input int n);
      while (step != n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // hi[i]: force source i to a held-high square (div 2 for two edges, then a very long divisor)
   task automatic run_phase(input logic [21:0] bl, input logic [21:0] br, input logic [21:0] sl,
                            input logic [21:0] sr, input logic [15:0] ba, input logic [15:0] sa,
                            input logic [3:0] hi, input int chg_step, input logic [21:0] chg_div,
                            input int frames);
      logic [21:0] dv [4];
      dv[0] = bl; dv[1] = br; dv[2] = sl; dv[3] = sr;
      @(posedge clk);
      #2;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_div(i, hi[i] ? 22'd2 : dv[i]);
         base_n[i]  = 0;
         base_sq[i] = 1'b0;
      end
      bgm_amplitude = ba;
      sfx_amplitude = sa;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      if (hi != 4'd0) begin
         wait_step(2);
         for (int i = 0; i < 4; i++)
            if (hi[i]) retune(i, 2, 22'd4000000);
      end
      if (chg_step > 2) begin
         wait_step(chg_step);
         retune(0, chg_step, chg_div);
      end
      wait_step(frames * 512 + 300);
   endtask

   // Monitor: clock pins, reset state, scoreboard push at capture, serial decode and pop
   initial begin
      int slot;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            got_l = '0;
            got_r = '0;
         end else begin
            if (fresh) begin
               check_val("rst_mclk", 32'(audio_mclk), 32'd0);
               check_val("rst_sck", 32'(audio_sck), 32'd0);
               check_val("rst_lrck", 32'(audio_lrck), 32'd0);
               check_val("rst_sdin", 32'(audio_sdin), 32'd0);
               exp_q.push_back(32'd0);
            end
            check_val("mclk", 32'(audio_mclk), 32'(step[1]));
            check_val("sck", 32'(audio_sck), 32'(step[3]));
            check_val("lrck", 32'(audio_lrck), 32'(step[8]));
            if (step % 512 == 511)
               exp_q.push_back({mix_exp(0, step), mix_exp(1, step)});
            if (step % 16 == 8) begin
               slot = (step / 16) % 32;
               if (slot >= 1 && slot <= 15) got_l[16 - slot] = audio_sdin;
               else if (slot == 16) got_l[0] = audio_sdin;
               else if (slot >= 17) got_r[32 - slot] = audio_sdin;
               else if (step >= 512) begin
                  got_r[0] = audio_sdin;
                  check_val("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     check_val("word_l", 32'(got_l), 32'(e[31:16]));
                     check_val("word_r", 32'(got_r), 32'(e[15:0]));
                     $display("frame end step %0d: left %h (exp %h) right %h (exp %h)",
                              step, got_l, e[31:16], got_r, e[15:0]);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bgm_note_div_left = 22'd1;
      bgm_note_div_right = 22'd1;
      sfx_note_div_left = 22'd1;
      sfx_note_div_right = 22'd1;
      bgm_amplitude = '0;
      sfx_amplitude = '0;
      //          bl          br          sl          sr          ba        sa        hi       chg   cdiv    fr
      run_phase(22'd1,      22'd1,      22'd1,      22'd1,      16'h1234, 16'h4321, 4'b0000, 0,    22'd0,  2);
      run_phase(22'd100,    22'd1,      22'd1,      22'd1,      16'h1000, 16'h7777, 4'b0000, 0,    22'd0,  4);
      run_phase(22'd4000000, 22'd1,     22'd1,      22'd1,      16'h5A3D, 16'h3C5A, 4'b1000, 0,    22'd0,  3);
      run_phase(22'd4000000, 22'd4000000, 22'd4000000, 22'd4000000, 16'h7FFF, 16'h7FFF, 4'b0000, 0, 22'd0, 2);
      run_phase(22'd1,      22'd1,      22'd1,      22'd1,      16'h7FFF, 16'h7FFF, 4'b1111, 0,    22'd0,  2);
      run_phase(22'd4000000, 22'd4000000, 22'd1,    22'd1,      16'hFFFF, 16'h0000, 4'b0000, 0,    22'd0,  2);
      run_phase(22'd1,      22'd1,      22'd1,      22'd1,      16'hFFFF, 16'h0000, 4'b0011, 0,    22'd0,  2);
      run_phase(22'd2000,   22'd1,      22'd1,      22'd1,      16'h1000, 16'h0000, 4'b0000, 1022, 22'd50, 4);
      run_phase(22'd1,      22'd1,      22'd1,      22'd1,      16'h2000, 16'h1000, 4'b0111, 0,    22'd0,  2);
      run_phase(22'd100,    22'd77,     22'd37,     22'd1000,   16'h3000, 16'h6000, 4'b0000, 0,    22'd0,  4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/speaker_drive.md
# speaker_drive

Final audio stage of the whack-a-mole sound path. Takes the BGM note divisors and amplitude plus the one-shot sound-effect note divisors and amplitude, and synthesises one square-wave tone per source per channel. It mixes BGM and SFX per channel with saturation and serialises the stereo result as 16-bit I2S to the Pmod I2S DAC. It is the direct consumer of the sound-effect generator and the BGM player outputs.

## Interface

Parameters:
- `DIV_W`, 22: note-divisor width.
- `AMP_W`, 16: amplitude and sample width.

Ports:
- `clk`  in  1  100 MHz system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `bgm_note_div_left`  in  22  BGM half-period in clk cycles, left channel.
- `bgm_note_div_right`  in  22  BGM half-period in clk cycles, right channel.
- `bgm_amplitude`  in  16  BGM magnitude, unsigned.
- `sfx_note_div_left`  in  22  SFX half-period, left channel.
- `sfx_note_div_right`  in  22  SFX half-period, right channel.
- `sfx_amplitude`  in  16  SFX magnitude, unsigned.
- `audio_mclk`  out  1  DAC master clock, clk/4.
- `audio_lrck`  out  1  word select, clk/512; low = left.
- `audio_sck`  out  1  bit clock, clk/16.
- `audio_sdin`  out  1  serial data, MSB first, I2S one-bit delay.

## Operation

Tone generators: four independent generators (BGM-L, BGM-R, SFX-L, SFX-R), each with a 22-bit counter `tc` and a square bit `sq`.
- Silence: `div <= 1`. In this case `tc` is held at 0, `sq` is held at 0, and the sample is 0.
- Otherwise, each clk:
  - if `tc >= div-1`: `tc <= 0`, `sq <= ~sq`;
  - else `tc <= tc+1`.
- Tone period is therefore 2·div clk cycles. Because the compare uses `>=`, lowering `div` mid-tone never causes a 2^22 wrap.
- Magnitude: `mag = min(amplitude, 16'h7FFF)`.
- Per-source sample: `sq ? +mag : -mag`, 16-bit signed.

Mixer, per channel:
- `sum = sext17(bgm) + sext17(sfx)`.
- Saturate to the range [-32768, 32767].
- Purely combinational from the generator registers.

Clock divider: 9-bit free-running counter `cnt`, cleared at reset.
- `audio_mclk = cnt[1]`
- `audio_sck = cnt[3]`
- `audio_lrck = cnt[8]`
- All three are driven straight from register bits, with no glitches.

Serialiser:
- Capture: when `cnt == 511`, `word_l <= mix_l` and `word_r <= mix_r`. `word_r` is copied to `prev_r` before it is overwritten.
- Slot definition: slot `s = cnt[7:4]` (0..15) within each half-frame.
- Data order: I2S with one-bit delay.
  - Left half (lrck = 0): slot 0 carries `prev_r[0]`; slot `s` (1..15) carries `word_l[16-s]`.
  - Right half (lrck = 1): slot 0 carries `word_l[0]`; slot `s` carries `word_r[16-s]`.
- `audio_sdin` is a register. It loads the new slot's bit on the clk edge where `cnt[3:0]` becomes 0, which coincides with the falling edge of `audio_sck`. The DAC samples on the rising edge of `audio_sck`.

## Timing

- Reset: `cnt`, all `tc` and `sq`, `word_l`, `word_r`, `prev_r` and `audio_sdin` are all 0. Every output is 0 on the first cycle after `rst`.
- Reset mid-frame: immediate. `lrck` restarts low on the next cycle.
- Frame: 512 clk, i.e. 195.3 kHz sample rate.
- Latency, `div`/amplitude input to DAC: first use of a changed divisor is the next clk. Mixed samples are captured once per frame at `cnt == 511`. A sample's MSB appears on `audio_sdin` at `cnt == 16` (left) or `cnt == 272` (right).
- Simultaneous events:
  - `tc` wrap and a `div` change in the same cycle: the compare uses the old (registered-input) `div` for that cycle.
  - SFX becomes silent mid-frame: affects only the next capture.
- Inputs are assumed synchronous to `clk`. No handshake is used; inputs are sampled every cycle.

## Configuration

- `SPEAKER_DUCK_EN` defined: on each channel whose SFX divisor is > 1, the BGM sample is arithmetic-shifted right by 1 before mixing (−6 dB ducking). Ducking is applied per channel and combinationally.
- `SPEAKER_DUCK_EN` undefined: BGM is mixed at full level. No shifter logic is present.

## Test plan

1. Reset, then run. Required:
   - `audio_lrck` period 512 clk, `audio_sck` period 16 clk, `audio_mclk` period 4 clk.
   - All outputs 0 for the first cycle after reset.
2. BGM-L `div = 100`, `bgm_amplitude = 0x1000`, SFX silent (`div = 1`). Required:
   - BGM-L square period = 200 clk.
   - Captured `word_l` ∈ {0x1000, 0xF000}.
   - `word_r` = 0 when BGM-R `div = 1`.
3. Serial format: force `mix_l = 0xA5C3` and `mix_r = 0x3C5A` at capture. Required:
   - Left slots 1..15 carry 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1.
   - Next right-half slot 0 carries 1.
   - The next frame's left slot 0 carries 0.
4. Saturation: both sources `amplitude = 0x7FFF`, `sq` both high. Required: sample = 0x7FFF. Both low: sample = 0x8000. Also, `amplitude = 0xFFFF` is clamped to 0x7FFF.
5. Divisor shrink: `div` = 1000 with `tc` = 900, then `div` changes to 50. Required: `tc` wraps to 0 on the next clk and `sq` toggles.
6. With `SPEAKER_DUCK_EN`: BGM `amp = 0x2000` high, SFX `div = 50`, `amp = 0x1000` high. Required: sample = 0x2000 (0x1000 + 0x1000). Without the macro: sample = 0x3000.
